// File: rtl/sd_dfc_pkg.sv
// Shared types and constants for the delayed-flow-control receiver.
package sd_dfc_pkg;

  typedef enum logic {
    FC_STOP = 1'b0,
    FC_GO   = 1'b1
  } fc_state_e;

  localparam int unsigned DROP_CW = 8;

endpackage

// File: rtl/sd_dfc_rx_chan.sv
// One receive channel: registered force-stop, hysteresis go/stop FSM,
// sticky overflow flag and saturating drop counter.
module sd_dfc_rx_chan
  import sd_dfc_pkg::*;
#(
  parameter int unsigned usz    = 5,
  parameter int unsigned thd_hi = 4,
  parameter int unsigned thd_lo = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               force_stop,
  input  logic [usz-1:0]     usage,
  input  logic               pop_vld,
  input  logic               drop,
  input  logic               ovf_clr,
  output logic               fc_n,
  output logic               overflow,
  output logic [DROP_CW-1:0] drop_cnt
);

  fc_state_e          state_q, state_d;
  logic               fs_q;
  logic               ovf_q, ovf_d;
  logic [DROP_CW-1:0] cnt_q, cnt_d;
  logic               at_hi, at_lo;

  assign at_hi = 32'(usage) >= thd_hi;
  assign at_lo = 32'(usage) <= thd_lo;

  always_comb begin
    state_d = state_q;
    case (state_q)
      FC_STOP: if (!fs_q && (at_lo || pop_vld)) state_d = FC_GO;
      FC_GO:   if (fs_q || (at_hi && !pop_vld)) state_d = FC_STOP;
      default: state_d = FC_STOP;
    endcase
  end

  // A drop coincident with a clear leaves exactly that one drop counted.
  always_comb begin
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (ovf_clr) begin
        cnt_d = DROP_CW'(1);
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + DROP_CW'(1);
      end
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fs_q    <= 1'b1;
      state_q <= FC_STOP;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      fs_q    <= force_stop;
      state_q <= state_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fc_n     = (state_q == FC_GO);
  assign overflow = ovf_q;
  assign drop_cnt = cnt_q;

endmodule

// File: rtl/sd_dfc_rx_mc.sv
// Multi-channel delayed-flow-control receiver: steers link beats to per-channel
// FIFOs and returns a hysteresis-controlled fc_n per channel.
module sd_dfc_rx_mc
  import sd_dfc_pkg::*;
#(
  parameter int unsigned width   = 8,
  parameter int unsigned chans   = 4,
  parameter int unsigned rt_lat  = 8,
  parameter int unsigned thd_hi  = 4,
  parameter int unsigned thd_lo  = 2,
  parameter int unsigned regcout = 1,
  parameter int unsigned regcin  = 1,
  localparam int unsigned cw     = $clog2(chans),
  localparam int unsigned depth  = rt_lat + thd_hi + regcout + regcin + 2,
  localparam int unsigned usz    = $clog2(depth + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     c_vld,
  input  logic [cw-1:0]            c_chan,
  input  logic [width-1:0]         c_data,
  output logic [chans-1:0]         c_fc_n,
  input  logic [chans-1:0]         force_stop,
  output logic [chans-1:0]         f_srdy,
  input  logic [chans-1:0]         f_drdy,
  output logic [width-1:0]         f_data,
  input  logic [chans*usz-1:0]     f_usage,
  input  logic [chans-1:0]         f_pop_vld,
  output logic [chans-1:0]         overflow,
  output logic [chans*DROP_CW-1:0] drop_cnt,
  input  logic [chans-1:0]         ovf_clr,
  output logic                     err_chan
);

  logic             ic_vld;
  logic [cw-1:0]    ic_chan;
  logic [width-1:0] ic_data;
  logic [chans-1:0] fc_int;
  logic             err_q;

  if (regcin != 0) begin : g_regcin
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ic_vld <= 1'b0;
      else        ic_vld <= c_vld;
    end
    // Payload and channel id carry no reset; ic_vld qualifies them.
    always_ff @(posedge clk) begin
      ic_chan <= c_chan;
      ic_data <= c_data;
    end
  end else begin : g_nocin
    assign ic_vld  = c_vld & rst_n;
    assign ic_chan = c_chan;
    assign ic_data = c_data;
  end

  assign f_data = ic_data;

  for (genvar i = 0; i < chans; i++) begin : g_chan
    logic hit;
    assign hit       = ic_vld && (ic_chan == cw'(i));
    assign f_srdy[i] = hit;

    sd_dfc_rx_chan #(
      .usz    (usz),
      .thd_hi (thd_hi),
      .thd_lo (thd_lo)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .force_stop (force_stop[i]),
      .usage      (f_usage[i*usz +: usz]),
      .pop_vld    (f_pop_vld[i]),
      .drop       (hit && !f_drdy[i]),
      .ovf_clr    (ovf_clr[i]),
      .fc_n       (fc_int[i]),
      .overflow   (overflow[i]),
      .drop_cnt   (drop_cnt[i*DROP_CW +: DROP_CW])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= ic_vld && (32'(ic_chan) >= chans);
  end

  assign err_chan = err_q;

  if (regcout != 0) begin : g_regcout
    logic [chans-1:0] fc_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fc_q <= '0;
      else        fc_q <= fc_int;
    end
    assign c_fc_n = fc_q;
  end else begin : g_nocout
    assign c_fc_n = fc_int;
  end

endmodule

// File: tb/tb_sd_dfc_rx_mc.sv
// Directed bench for sd_dfc_rx_mc: a cycle model checked on every negedge plus
// hand-computed literal expectations on key timing points.
module tb_sd_dfc_rx_mc;

  localparam int CH  = 4;
  localparam int USZ = 5;  // depth = 8+4+1+1+2 = 16 -> $clog2(17) = 5
  localparam int HI  = 4;
  localparam int LO  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              c_vld;
  logic [1:0]        c_chan;
  logic [7:0]        c_data;
  logic [CH-1:0]     c_fc_n, force_stop, f_srdy, f_drdy, f_pop_vld, overflow, ovf_clr;
  logic [7:0]        f_data;
  logic [CH*USZ-1:0] f_usage;
  logic [CH*8-1:0]   drop_cnt;
  logic              err_chan;

  // Three-channel build for the out-of-range channel case.
  logic       c_vld3;
  logic [1:0] c_chan3;
  logic [2:0] c_fc_n3, f_srdy3, overflow3;
  logic [7:0] f_data3;
  logic [23:0] drop_cnt3;
  logic       err_chan3;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sd_dfc_rx_mc dut (
    .clk(clk), .rst_n(rst_n), .c_vld(c_vld), .c_chan(c_chan), .c_data(c_data),
    .c_fc_n(c_fc_n), .force_stop(force_stop), .f_srdy(f_srdy), .f_drdy(f_drdy),
    .f_data(f_data), .f_usage(f_usage), .f_pop_vld(f_pop_vld), .overflow(overflow),
    .drop_cnt(drop_cnt), .ovf_clr(ovf_clr), .err_chan(err_chan)
  );

  sd_dfc_rx_mc #(.chans(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .c_vld(c_vld3), .c_chan(c_chan3), .c_data(8'h5a),
    .c_fc_n(c_fc_n3), .force_stop(3'b000), .f_srdy(f_srdy3), .f_drdy(3'b111),
    .f_data(f_data3), .f_usage(15'd0), .f_pop_vld(3'b000), .overflow(overflow3),
    .drop_cnt(drop_cnt3), .ovf_clr(3'b000), .err_chan(err_chan3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: each output is the spec's rule applied to inputs seen
  // a fixed number of edges earlier.
  logic [CH-1:0] m_fs, m_go, m_fc, m_ovf;
  int            m_cnt[CH];
  logic          m_iv, m_err;
  int            m_ich;
  logic [7:0]    m_idat;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fs = '1; m_go = '0; m_fc = '0; m_ovf = '0; m_iv = 1'b0; m_err = 1'b0;
      for (int i = 0; i < CH; i++) m_cnt[i] = 0;
    end else begin
      m_fc = m_go;
      for (int i = 0; i < CH; i++) begin
        int  u;
        bit  stop_req, go_req, drop;
        u        = int'(f_usage[i*USZ +: USZ]);
        stop_req = m_fs[i] || (u >= HI && !f_pop_vld[i]);
        go_req   = !m_fs[i] && (u <= LO || f_pop_vld[i]);
        m_go[i]  = m_go[i] ? !stop_req : go_req;
        drop     = m_iv && m_ich == i && !f_drdy[i];
        if (drop) begin
          m_ovf[i] = 1'b1;
          m_cnt[i] = ovf_clr[i] ? 1 : (m_cnt[i] >= 255 ? 255 : m_cnt[i] + 1);
        end else if (ovf_clr[i]) begin
          m_ovf[i] = 1'b0;
          m_cnt[i] = 0;
        end
      end
      m_err  = m_iv && m_ich >= CH;
      m_fs   = force_stop;
      m_iv   = c_vld;
      m_ich  = int'(c_chan);
      m_idat = c_data;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic [CH-1:0] e_srdy;
      e_srdy = '0;
      if (m_iv && m_ich < CH) e_srdy[m_ich] = 1'b1;
      check("m_fc_n", 32'(c_fc_n), 32'(m_fc));
      check("m_srdy", 32'(f_srdy), 32'(e_srdy));
      check("m_ovf", 32'(overflow), 32'(m_ovf));
      check("m_err", 32'(err_chan), 32'(m_err));
      if (m_iv) check("m_fdata", 32'(f_data), 32'(m_idat));
      for (int i = 0; i < CH; i++) check("m_drop", 32'(drop_cnt[i*8 +: 8]), m_cnt[i]);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_use(input int ch, input int val);
    f_usage[ch*USZ +: USZ] = USZ'(val);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; c_vld = 1'b0; c_chan = '0; c_data = '0; force_stop = '0;
    f_drdy = '1; f_pop_vld = '0; f_usage = '0; ovf_clr = '0;
    c_vld3 = 1'b0; c_chan3 = '0;
    step(3);
    check("rst_fc_n", 32'(c_fc_n), 0);
    check("rst_srdy", 32'(f_srdy), 0);
    check("rst_err", 32'(err_chan), 0);

    // Reset release: fs clears, then GO, then registered fc_n.
    rst_n = 1'b1;
    step(2);
    check("restart_early", 32'(c_fc_n), 0);
    step(1);
    check("restart_go", 32'(c_fc_n), 32'hf);

    // Hysteresis on channel 2.
    for (int k = 1; k <= 3; k++) begin set_use(2, k); step(1); end
    set_use(2, 4);
    step(1);
    check("hys_hold_1", 32'(c_fc_n[2]), 1);
    step(1);
    check("hys_stop", 32'(c_fc_n), 32'hb);
    set_use(2, 5); step(2);
    set_use(2, 4); step(1);
    set_use(2, 3); step(3);
    check("hys_band", 32'(c_fc_n[2]), 0);
    set_use(2, 2);
    step(1);
    check("hys_lo_1", 32'(c_fc_n[2]), 0);
    step(1);
    check("hys_restart", 32'(c_fc_n), 32'hf);
    set_use(2, 0);

    // Pop keeps channel 1 going above the high threshold.
    set_use(1, 6); f_pop_vld[1] = 1'b1;
    step(4);
    check("pop_hold", 32'(c_fc_n[1]), 1);
    f_pop_vld[1] = 1'b0;
    step(1);
    check("pop_drop_1", 32'(c_fc_n[1]), 1);
    step(1);
    check("pop_stop", 32'(c_fc_n), 32'hd);
    set_use(1, 0); step(3);

    // Force-stop on channel 3 reaches c_fc_n after 3 edges.
    force_stop[3] = 1'b1;
    step(2);
    check("fs_early", 32'(c_fc_n[3]), 1);
    step(1);
    check("fs_stop", 32'(c_fc_n), 32'h7);
    force_stop[3] = 1'b0;
    step(3);
    check("fs_release", 32'(c_fc_n), 32'hf);

    // Overflow saturation on channel 0, interleaved good beats on channel 3.
    f_drdy[0] = 1'b0;
    for (int i = 0; i < 300; i++) begin
      c_vld = 1'b1; c_chan = (i % 7 == 0) ? 2'd3 : 2'd0; c_data = 8'(i);
      step(1);
    end
    c_vld = 1'b0;
    step(3);
    check("ovf_set", 32'(overflow), 32'h1);
    check("ovf_sat", 32'(drop_cnt[7:0]), 255);
    ovf_clr[0] = 1'b1;
    step(1);
    ovf_clr[0] = 1'b0;
    check("clr_ovf", 32'(overflow[0]), 0);
    check("clr_cnt", 32'(drop_cnt[7:0]), 0);
    c_vld = 1'b1; c_chan = 2'd0;
    step(1);
    c_vld = 1'b0; ovf_clr[0] = 1'b1;
    step(1);
    ovf_clr[0] = 1'b0;
    check("setclr_ovf", 32'(overflow[0]), 1);
    check("setclr_cnt", 32'(drop_cnt[7:0]), 1);
    f_drdy = '1; ovf_clr = '1;
    step(1);
    ovf_clr = '0;

    // Out-of-range channel on the three-channel build.
    c_vld3 = 1'b1; c_chan3 = 2'd2;
    step(1);
    check("b3_srdy_ok", 32'(f_srdy3), 32'h4);
    c_chan3 = 2'd3;
    step(1);
    check("b3_srdy_bad", 32'(f_srdy3), 0);
    check("b3_err_early", 32'(err_chan3), 0);
    c_vld3 = 1'b0;
    step(1);
    check("b3_err", 32'(err_chan3), 1);
    step(1);
    check("b3_err_end", 32'(err_chan3), 0);

    // Asynchronous reset in the middle of a dropping burst on channel 1.
    f_drdy[1] = 1'b0;
    c_vld = 1'b1; c_chan = 2'd1;
    step(5);
    check("burst_ovf", 32'(overflow[1]), 1);
    check("burst_srdy", 32'(f_srdy), 32'h2);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_srdy", 32'(f_srdy), 0);
    check("arst_fc_n", 32'(c_fc_n), 0);
    check("arst_ovf", 32'(overflow), 0);
    check("arst_drop", drop_cnt, 0);
    c_vld = 1'b0; f_drdy = '1;
    step(2);
    rst_n = 1'b1;
    step(3);
    check("arst_restart", 32'(c_fc_n), 32'hf);
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
